vector_tile_buffer: RTL and testbench
=====================================

# vector_tile_buffer

On-chip tile store that sits directly downstream of the vector DRAM loader. It captures each tile the loader emits (tile strobe plus a full-tile data bus) into a tile-addressed buffer, starting at a caller-chosen base index. It signals completion when the loader reports end-of-transfer, and exposes a registered read port to the compute datapath.

## Interface
- `TILE_WIDTH`, default 256: bits per tile.
- `DATA_WIDTH`, default 8: bits per element.
- `NUM_TILES`, default 32: buffer depth in tiles; must be a power of two ≥ 2.
- Derived: `ELEM_COUNT = TILE_WIDTH/DATA_WIDTH`, `AW = $clog2(NUM_TILES)`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_start`  in  1  begin a new fill; sampled only in IDLE.
- `wr_base`  in  AW  first tile index for the fill; sampled with `wr_start`.
- `tile_in_valid`  in  1  one-cycle strobe: `tile_in` holds one complete tile.
- `tile_in`  in  `DATA_WIDTH` × `ELEM_COUNT` (unpacked)  tile elements; element 0 is the lowest address.
- `load_done`  in  1  one-cycle strobe: the loader finished; may coincide with the final `tile_in_valid`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `tiles_written`  out  AW+1  tiles stored in the current or most recent fill.
- `overflow`  out  1  sticky; a tile was dropped because the fill already held `NUM_TILES` tiles.
- `rd_en`  in  1  read request.
- `rd_addr`  in  AW  tile index to read.
- `rd_data`  out  `DATA_WIDTH` × `ELEM_COUNT`  registered read data.
- `rd_valid`  out  1  `rd_data` is valid for the request issued on the previous cycle.

## Operation
- Storage: `NUM_TILES` entries of `ELEM_COUNT` elements each. Contents are not cleared by reset.
- State machine with three states: IDLE, FILL, DONE.
  - IDLE: if `wr_start`, load `wr_ptr ← wr_base`, `tiles_written ← 0`, `overflow ← 0`, then go to FILL. `tile_in_valid` and `load_done` are ignored in IDLE.
  - FILL, on `tile_in_valid`:
    - If `tiles_written < NUM_TILES`: write `tile_in` to `buf[wr_ptr]`, set `wr_ptr ← wr_ptr+1` (mod `NUM_TILES`, wraps from `NUM_TILES-1` to 0), and set `tiles_written ← tiles_written+1`.
    - Otherwise: discard the tile and set `overflow ← 1`.
  - FILL, on `load_done`: go to DONE. If `tile_in_valid` is high in the same cycle, that tile is processed first.
  - FILL, `wr_start` is ignored.
  - DONE: `done` = 1 for exactly this cycle, then return to IDLE. `wr_start` in DONE is ignored.
- `load_done` with zero tiles written is legal. `done` still pulses and `tiles_written` = 0.
- Read port (independent of the FSM, active in every state):
  - On `rd_en`, register `buf[rd_addr]` into `rd_data` and set `rd_valid ← 1`.
  - Without `rd_en`, `rd_valid ← 0` and `rd_data` holds its last value.
- Read and write to the same index in the same cycle: `rd_data` returns the pre-write contents (read-before-write).
- `tiles_written` and `overflow` hold their values after DONE until the next accepted `wr_start`.
- Reset mid-fill: on the next edge with `rst_n` = 0, state → IDLE and the fill is abandoned. Any partially written entries remain in storage.

## Timing
- Reset values: `busy` 0, `done` 0, `tiles_written` 0, `overflow` 0, `rd_valid` 0, `rd_data` all zeros. Internal `wr_ptr` resets to 0.
- `wr_start` sampled at edge N → `busy` = 1 from cycle N+1.
- `tile_in_valid` at edge N → the entry is readable by an `rd_en` issued at edge N+1, with data appearing at N+2.
- `load_done` at edge N → `done` = 1 during cycle N+1, `busy` = 0 from cycle N+2. The earliest next `wr_start` is accepted at edge N+2.
- Read latency is exactly 1 cycle. Back-to-back reads give one result per cycle.
- Accepts `tile_in_valid` every cycle (no backpressure). The minimum loader spacing is wider than this.

## Test plan
- Basic fill: `wr_base`=0; 3 tiles with element `i` of tile `t` = `t*32+i`, and `load_done` coincident with tile 2 → `done` pulses the next cycle, `tiles_written`=3, reads of indices 0..2 return exact data with 1-cycle `rd_valid`.
- Wrap-around: `NUM_TILES`=32, `wr_base`=30, 4 tiles → data lands at indices 30, 31, 0, 1; index 2 is untouched.
- Overflow: 33 tiles into a 32-deep buffer from base 0 → `tiles_written`=32, `overflow`=1, index 0 holds tile 0 (not tile 32); `overflow` clears on the next `wr_start`.
- Ignore rules: `tile_in_valid` in IDLE does not write; `wr_start` during FILL does not change `wr_ptr`; `load_done` with no tiles → `done` pulse with `tiles_written`=0.
- Read/write collision: read index 5 in the same cycle tile 5 is written → old data returned; a read on the next cycle returns the new data.
- Reset mid-fill: `rst_n`=0 after 2 of 4 tiles → all outputs at reset values next cycle; a subsequent full fill completes normally.

Source files
------------

// File: rtl/vector_tile_buffer.sv
// rtl/vector_tile_buffer.sv - tile-addressed capture buffer behind the vector DRAM loader
// Fills from a caller-chosen base index, pulses done on loader end-of-transfer, registered read port.
module vector_tile_buffer #(
    parameter  int TILE_WIDTH = 256,
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_TILES  = 32,
    localparam int ELEM_COUNT = TILE_WIDTH / DATA_WIDTH,
    localparam int AW         = $clog2(NUM_TILES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_start,
    input  logic [AW-1:0]         wr_base,
    input  logic                  tile_in_valid,
    input  logic [DATA_WIDTH-1:0] tile_in [ELEM_COUNT],
    input  logic                  load_done,
    output logic                  busy,
    output logic                  done,
    output logic [AW:0]           tiles_written,
    output logic                  overflow,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data [ELEM_COUNT],
    output logic                  rd_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam logic [AW:0] TILES_FULL = (AW+1)'(NUM_TILES);

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]           tiles_written_q, tiles_written_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q [ELEM_COUNT];
    logic [DATA_WIDTH-1:0] rd_data_d [ELEM_COUNT];
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] mem_q [NUM_TILES][ELEM_COUNT];

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        tiles_written_d = tiles_written_q;
        overflow_d      = overflow_q;
        wr_en           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_start) begin
                    wr_ptr_d        = wr_base;
                    tiles_written_d = '0;
                    overflow_d      = 1'b0;
                    state_d         = ST_FILL;
                end
            end
            ST_FILL: begin
                // A tile arriving with load_done is still stored before the fill closes.
                if (tile_in_valid) begin
                    if (tiles_written_q < TILES_FULL) begin
                        wr_en           = 1'b1;
                        wr_ptr_d        = wr_ptr_q + 1'b1;
                        tiles_written_d = tiles_written_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (load_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            tiles_written_q <= '0;
            overflow_q      <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '{default: '0};
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            tiles_written_q <= tiles_written_d;
            overflow_q      <= overflow_d;
            rd_valid_q      <= rd_valid_d;
            rd_data_q       <= rd_data_d;
        end
    end

    // Storage is never cleared; the read path samples the old row, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_ptr_q] <= tile_in;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign tiles_written = tiles_written_q;
    assign overflow      = overflow_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_vector_tile_buffer.sv
// tb/tb_vector_tile_buffer.sv - self-checking bench for vector_tile_buffer
// Directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_vector_tile_buffer;
    localparam int N  = 32;
    localparam int DW = 8;
    localparam int EC = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_start;
    logic [AW-1:0] wr_base;
    logic          tile_in_valid;
    logic [DW-1:0] tile_in [EC];
    logic          load_done;
    logic          busy;
    logic          done;
    logic [AW:0]   tiles_written;
    logic          overflow;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data [EC];
    logic          rd_valid;

    vector_tile_buffer #(
        .TILE_WIDTH(EC*DW),
        .DATA_WIDTH(DW),
        .NUM_TILES (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_start     (wr_start),
        .wr_base      (wr_base),
        .tile_in_valid(tile_in_valid),
        .tile_in      (tile_in),
        .load_done    (load_done),
        .busy         (busy),
        .done         (done),
        .tiles_written(tiles_written),
        .overflow     (overflow),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = idle, 1 = collecting tiles, 2 = completion cycle.
    logic [DW-1:0] m_mem [N][EC];
    bit            m_known [N];
    logic [DW-1:0] m_rd [EC];
    int            m_mode = 0;
    int            m_ptr = 0;
    int            m_count = 0;
    bit            m_ov = 0;
    bit            m_rv = 0;
    bit            m_rd_known = 0;
    bit            m_init = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 1;
            m_mode = 0; m_ptr = 0; m_count = 0; m_ov = 0; m_rv = 0;
            for (int e = 0; e < EC; e++) m_rd[e] = '0;
            m_rd_known = 1;
        end else begin
            if (rd_en) begin
                m_rv = 1;
                m_rd = m_mem[rd_addr];
                m_rd_known = m_known[rd_addr];
            end else begin
                m_rv = 0;
            end
            if (m_mode == 0) begin
                if (wr_start) begin
                    m_ptr = int'(wr_base); m_count = 0; m_ov = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (tile_in_valid) begin
                    if (m_count < N) begin
                        m_mem[m_ptr] = tile_in;
                        m_known[m_ptr] = 1;
                        m_ptr = (m_ptr + 1) % N;
                        m_count++;
                    end else begin
                        m_ov = 1;
                    end
                end
                if (load_done) m_mode = 2;
            end else begin
                m_mode = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            int nbad;
            int first_bad;
            chk("busy", 64'(busy), 64'(m_mode != 0));
            chk("done", 64'(done), 64'(m_mode == 2));
            chk("tiles_written", 64'(tiles_written), 64'(m_count));
            chk("overflow", 64'(overflow), 64'(m_ov));
            chk("rd_valid", 64'(rd_valid), 64'(m_rv));
            if (m_rd_known) begin
                nbad = 0;
                first_bad = 0;
                for (int e = EC - 1; e >= 0; e--) begin
                    if (rd_data[e] !== m_rd[e]) begin
                        nbad++;
                        first_bad = e;
                    end
                end
                chk($sformatf("rd_data elem %0d", first_bad), 64'(rd_data[first_bad]), 64'(m_rd[first_bad]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clr();
        wr_start = 0; tile_in_valid = 0; load_done = 0; rd_en = 0;
    endtask

    task automatic put_tile(input int t, input int mul);
        tile_in_valid = 1;
        for (int i = 0; i < EC; i++) tile_in[i] = DW'(t * mul + i);
    endtask

    task automatic start(input int base);
        wr_start = 1; wr_base = AW'(base);
        step();
        clr();
    endtask

    task automatic rd(input int a);
        rd_en = 1; rd_addr = AW'(a);
        step();
        rd_en = 0;
    endtask

    initial begin
        rst_n = 0; wr_base = '0; rd_addr = '0;
        clr();
        for (int i = 0; i < EC; i++) tile_in[i] = '0;
        repeat (3) step();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset tiles_written", 64'(tiles_written), 64'd0);
        chk("reset rd_data", 64'(rd_data[0]), 64'd0);
        rst_n = 1;
        step();

        // Basic fill, load_done with the last tile.
        start(0);
        chk("busy after start", 64'(busy), 64'd1);
        for (int t = 0; t < 3; t++) begin
            put_tile(t, 32);
            load_done = (t == 2);
            step();
            clr();
        end
        chk("basic done", 64'(done), 64'd1);
        chk("basic count", 64'(tiles_written), 64'd3);
        step();
        for (int a = 0; a < 3; a++) begin
            rd(a);
            if (a == 1) chk("basic tile1 elem3", 64'(rd_data[3]), 64'd35);
        end
        step();

        // Wrap-around from index 30.
        start(30);
        for (int t = 0; t < 4; t++) begin
            put_tile(100 + t, 32);
            step();
            clr();
        end
        load_done = 1; step(); clr(); step();
        for (int k = 0; k < 5; k++) begin
            rd((30 + k) % N);
            if (k == 2) chk("wrap idx0", 64'(rd_data[0]), 64'd192);
            if (k == 4) chk("wrap idx2 untouched", 64'(rd_data[0]), 64'd64);
        end

        // Overflow: 33 tiles into 32 entries.
        start(0);
        for (int t = 0; t < 33; t++) begin
            put_tile(t, 33);
            load_done = (t == 32);
            step();
            clr();
        end
        chk("ovf count", 64'(tiles_written), 64'd32);
        chk("ovf flag", 64'(overflow), 64'd1);
        step();
        chk("ovf sticky", 64'(overflow), 64'd1);
        rd(0);
        chk("ovf idx0 keeps tile0", 64'(rd_data[0]), 64'd0);
        start(7);
        chk("ovf cleared", 64'(overflow), 64'd0);

        // wr_start during FILL must not move the pointer.
        wr_start = 1; wr_base = AW'(20); put_tile(200, 1);
        step(); clr();
        load_done = 1; step(); clr(); step();
        rd(7);
        chk("restart ignored idx7", 64'(rd_data[0]), 64'd200);
        rd(20);
        chk("restart ignored idx20", 64'(rd_data[0]), 64'd148);

        // Tiles in IDLE are dropped.
        put_tile(250, 1); step(); clr();
        rd(8);
        chk("idle tile ignored", 64'(rd_data[0]), 64'd8);

        // load_done with no tiles.
        start(3);
        load_done = 1; step(); clr();
        chk("empty done", 64'(done), 64'd1);
        chk("empty count", 64'(tiles_written), 64'd0);
        step();

        // Read/write collision at index 5.
        start(5);
        put_tile(77, 1); rd_en = 1; rd_addr = AW'(5);
        step(); clr();
        chk("collision old data", 64'(rd_data[0]), 64'd165);
        rd_en = 1; rd_addr = AW'(5); load_done = 1;
        step(); clr();
        chk("collision new data", 64'(rd_data[0]), 64'd77);
        step();

        // Reset mid-fill, then a clean fill.
        start(12);
        for (int t = 0; t < 2; t++) begin
            put_tile(40 + t, 1); step(); clr();
        end
        rst_n = 0; put_tile(99, 1);
        step(); clr();
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset count", 64'(tiles_written), 64'd0);
        rst_n = 1; step();
        start(12);
        for (int t = 0; t < 4; t++) begin
            put_tile(60 + t, 1);
            load_done = (t == 3);
            step(); clr();
        end
        chk("refill done", 64'(done), 64'd1);
        chk("refill count", 64'(tiles_written), 64'd4);
        step();
        rd(14);
        chk("refill idx14", 64'(rd_data[0]), 64'd62);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 499) != 0);
            wr_start      = ($urandom_range(0, 3) == 0);
            wr_base       = AW'($urandom);
            tile_in_valid = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < EC; i++) tile_in[i] = DW'($urandom);
            load_done     = ($urandom_range(0, 15) == 0);
            rd_en         = ($urandom_range(0, 1) == 1);
            rd_addr       = AW'($urandom);
            step();
        end
        clr(); rst_n = 1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
